// File: rtl/matrix_frame_ctrl_if.sv
// Row-write bus shared by the two back-buffer writers (0 = game logic, 1 = overlay).
// master: a writer driving wr_req/wr_row/wr_red/wr_green and watching wr_gnt.
// slave : the frame controller, which returns the one-hot wr_gnt.
// A writer holds its request and data stable until it sees its grant bit.
interface matrix_frame_ctrl_if;
    logic [1:0]      wr_req;
    logic [1:0][2:0] wr_row;
    logic [1:0][7:0] wr_red;
    logic [1:0][7:0] wr_green;
    logic [1:0]      wr_gnt;

    modport master (
        output wr_req,
        output wr_row,
        output wr_red,
        output wr_green,
        input  wr_gnt
    );

    modport slave (
        input  wr_req,
        input  wr_row,
        input  wr_red,
        input  wr_green,
        output wr_gnt
    );
endinterface

// File: rtl/matrix_frame_ctrl.sv
// Double-buffered 8x8 red/green frame store and row-scan scheduler for matrix_driver.
// Two writers share the back buffer through a round-robin arbiter. The front buffer
// is replaced only on the last cycle of the scan frame, so the display never tears.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   wr (slave)           row-write bus: wr_req/wr_row/wr_red/wr_green in, wr_gnt out
//   commit               1-cycle pulse: back buffer holds a complete frame
//   blank                forces red_array/green_array to zero
//   swap_pending         commit accepted, waiting for frame end
//   swap_done            1-cycle pulse on the cycle after the swap
//   scan_row             row currently being scanned
//   frame_tick           high on the last cycle of row 7
//   red_array/green_array front frame (or zeros while blank)
//
// Build option: define MATRIX_CLEAR_ON_SWAP_EN to clear the back buffer after each
// swap; otherwise the back buffer is reloaded with a copy of the new front frame.
module matrix_frame_ctrl #(
    parameter int unsigned TICK_DIV = 1024,
    parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
    input  logic                clk,
    input  logic                reset_n,
    matrix_frame_ctrl_if.slave  wr,
    input  logic                commit,
    input  logic                blank,
    output logic                swap_pending,
    output logic                swap_done,
    output logic [2:0]          scan_row,
    output logic                frame_tick,
    output logic [7:0][7:0]     red_array,
    output logic [7:0][7:0]     green_array
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_DRAW    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] presc_q;
    logic [2:0]       row_q;
    logic             prio_q;       // client that wins the next tie
    logic [1:0]       gnt;
    logic [7:0][7:0]  front_red_q;
    logic [7:0][7:0]  front_green_q;
    logic [7:0][7:0]  back_red_q;
    logic [7:0][7:0]  back_green_q;

    // Free-running row scan, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            row_q   <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            row_q   <= row_q + 3'd1;
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

    assign frame_tick = (presc_q == PRESC_LAST) && (row_q == 3'd7);
    assign scan_row   = row_q;

    // Next state and arbitration; grants are only issued while drawing.
    always_comb begin
        state_d = state_q;
        gnt     = 2'b00;
        case (state_q)
            ST_DRAW: begin
                case (wr.wr_req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                    default: gnt = 2'b00;
                endcase
                if (commit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_tick) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_d = ST_DRAW;
            end
            default: begin
                state_d = ST_DRAW;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_DRAW;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin pointer: the client just served loses the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else if (gnt[0]) begin
            prio_q <= 1'b1;
        end else if (gnt[1]) begin
            prio_q <= 1'b0;
        end
    end

    // Front buffer takes the committed frame on the frame_tick edge only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_red_q   <= '0;
            front_green_q <= '0;
        end else if ((state_q == ST_PENDING) && frame_tick) begin
            front_red_q   <= back_red_q;
            front_green_q <= back_green_q;
        end
    end

    // Back buffer: refilled in SWAP, otherwise takes the granted row write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            back_red_q   <= '0;
            back_green_q <= '0;
        end else if (state_q == ST_SWAP) begin
`ifdef MATRIX_CLEAR_ON_SWAP_EN
            back_red_q   <= '0;
            back_green_q <= '0;
`else
            back_red_q   <= front_red_q;
            back_green_q <= front_green_q;
`endif
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (gnt[c]) begin
                    back_red_q[wr.wr_row[c]]   <= wr.wr_red[c];
                    back_green_q[wr.wr_row[c]] <= wr.wr_green[c];
                end
            end
        end
    end

    assign wr.wr_gnt     = gnt;
    assign swap_pending  = (state_q == ST_PENDING);
    assign swap_done     = (state_q == ST_SWAP);
    assign red_array     = blank ? '0 : front_red_q;
    assign green_array   = blank ? '0 : front_green_q;

endmodule

// File: doc/matrix_frame_ctrl.md
Name: matrix_frame_ctrl

Overview:
- Double-buffered frame store and scan scheduler for the 8x8 red/green LED matrix; drives red_array/green_array into matrix_driver.
- Shares the back buffer between two row-writers: client 0 is game logic, client 1 is the score/overlay. A round-robin arbiter decides which writer is served.
- Presents a stable front buffer to the display and swaps buffers only at the frame boundary of its own row scan, so no torn frames are shown.

Parameters:
TICK_DIV, 1024, clk cycles per scanned row (must be >= 2); a frame is 8*TICK_DIV cycles.
DIV_W, $clog2(TICK_DIV), width of the row prescaler.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
wr_req  input  [1:0]  per-client row-write request
wr_row  input  [1:0][2:0]  per-client target row
wr_red  input  [1:0][7:0]  per-client red row data
wr_green  input  [1:0][7:0]  per-client green row data
wr_gnt  output  [1:0]  one-hot grant; the write lands at this clk edge
commit  input  1  1-cycle pulse: back buffer is a complete frame
blank  input  1  forces displayed arrays to zero
swap_pending  output  1  commit accepted, waiting for frame end
swap_done  output  1  1-cycle pulse, cycle after swap
scan_row  output  [2:0]  row currently being scanned
frame_tick  output  1  1-cycle pulse on last cycle of row 7
red_array  output  [7:0][7:0]  front red frame to matrix_driver
green_array  output  [7:0][7:0]  front green frame to matrix_driver

Behaviour:
- Reset (async, reset_n=0):
  - front/back buffers = 0; prescaler = 0; scan_row = 0; state = DRAW.
  - wr_gnt = 0, swap_pending = 0, swap_done = 0, frame_tick = 0.
  - Reset mid-pending discards the pending swap and all buffer contents.
- Scan: prescaler counts 0..TICK_DIV-1 and wraps.
  - On wrap, scan_row increments mod 8.
  - frame_tick = (prescaler == TICK_DIV-1) && (scan_row == 7). It is combinational from registers.
  - The scan runs free in every state.
- Arbitration: only in state DRAW.
  - wr_gnt is combinational from wr_req and the rr pointer.
  - Only one requester → grant it.
  - Both requesters → grant the client not granted last; after reset, client 0 wins first.
  - Pointer updates only on a grant.
  - Granted write: back_red[wr_row] <= wr_red and back_green[wr_row] <= wr_green at that edge.
  - A client holds req and data stable until gnt is seen.
  - The ungranted client stays stalled, with no data loss.
- States:
  - DRAW: grants enabled. commit=1 → PENDING at the next edge. A write granted in the same cycle as commit is part of the committed frame.
  - PENDING: swap_pending=1 and wr_gnt=0. commit is ignored. On a frame_tick cycle: front <= back, go to SWAP.
  - SWAP (1 cycle): swap_done=1 and wr_gnt=0. The back buffer is refilled per the optional feature. → DRAW.
- Commit coincident with frame_tick while in DRAW: the swap does not occur at that edge; it waits one full frame (deterministic latency 1..8*TICK_DIV cycles).
- commit while in SWAP: ignored.
- Output gating:
  - red_array/green_array = front buffer, or all zeros while blank=1.
  - blank does not alter buffers, the scan or the FSM.

Optional Feature:
MATRIX_CLEAR_ON_SWAP_EN
- Defined: in SWAP the back buffer is cleared to all zeros, so every frame is drawn from scratch.
- Undefined: in SWAP the back buffer is loaded with a copy of the new front buffer, so writers update incrementally (only changed rows).
- Front-buffer behaviour and all timing are identical in both builds.

Test Plan:
- All tests use TICK_DIV=4 (frame = 32 cycles).
- Reset/scan: release reset_n. Expected: scan_row steps 0..7 every 4 cycles; frame_tick is high at cycle 31 and 63 only; arrays are 0.
- Single write + commit:
  - Stimulus: client 0 writes row 3 = red 8'hA5, green 8'h0F; commit at cycle 5.
  - Expected: swap_pending 1 from cycle 6; arrays change only after frame_tick at cycle 31 (red_array[3]=A5, green_array[3]=0F); swap_done at cycle 32.
- Contention:
  - Stimulus: both clients request continuously, client 0 row 1 = 8'h11, client 1 row 2 = 8'h22.
  - Expected: grants alternate 0,1,0,1; each gnt is one-hot.
  - Stimulus: drop client 0.
  - Expected: client 1 is granted every cycle.
- Pending stall: request during PENDING → wr_gnt=0 until the cycle after swap_done; the write then lands in the new back buffer.
- Coincident commit: commit on the frame_tick cycle (cycle 31) → no swap at 31; swap at cycle 63.
- Blank/reset: blank=1 with front nonzero → arrays 0, swap still occurs. reset_n low during PENDING → swap_pending 0, all buffers 0. Under MATRIX_CLEAR_ON_SWAP_EN, after a swap a write to only row 0 then commit → rows 1..7 display 0; without the macro they keep their prior values.
